itype_encoder: RTL

- Sequential I-type instruction encoder: accepts decoded fields (rd, rs1, funct3, 32-bit immediate) and emits 32-bit OP-IMM instruction words with sequential word addresses.
- Sits upstream of instruction memory as the program writer / loader.
- Builds the same word layout the I-type decode path splits apart.
- An immediate that does not fit 12 bits signed, with funct3=000 and rs1=x0, is expanded into a LUI + ADDI pair. Any other out-of-range immediate is rejected with an error pulse.

---
 rtl/itype_encoder_if.sv | 28 ++
 rtl/itype_encoder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/itype_encoder_if.sv
// Handshake bundle between a field source and the I-type encoder:
// decoded fields in, encoded instruction words with byte addresses out.
interface itype_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [2:0]        funct3;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic              busy;

    modport master (
        output in_valid, rd, rs1, funct3, imm, out_ready,
        input  in_ready, out_valid, out_word, out_addr, err, busy
    );

    modport slave (
        input  in_valid, rd, rs1, funct3, imm, out_ready,
        output in_ready, out_valid, out_word, out_addr, err, busy
    );
endinterface

// File: rtl/itype_encoder.sv
// Sequential OP-IMM instruction encoder: one word per bundle, or a LUI+ADDI pair
// when an x0-based ADDI immediate needs more than 12 signed bits.
module itype_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic           clk,
    input  logic           rst,
    itype_encoder_if.slave bus
);
    localparam logic [6:0]        OP_IMM = 7'b0010011;
    localparam logic [6:0]        OP_LUI = 7'b0110111;
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        HI     = 2'd2,
        LO     = 2'd3
    } state_t;

    state_t            state_r;
    logic              out_valid_r;
    logic [31:0]       out_word_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic [ADDR_W-1:0] addr_r;
    logic              err_r;
    logic [11:0]       imm_lo_r;
    logic [4:0]        rd_lat_r;

    logic              fits_s;
    logic              pair_ok_s;
    logic [19:0]       hi_s;

    function automatic logic [31:0] enc_itype(input logic [11:0] imm12, input logic [4:0] rs,
                                              input logic [2:0] f3, input logic [4:0] rd);
        return {imm12, rs, f3, rd, OP_IMM};
    endfunction

    function automatic logic [31:0] enc_utype(input logic [19:0] imm20, input logic [4:0] rd);
        return {imm20, rd, OP_LUI};
    endfunction

    // Range test and upper-half rounding: the ADDI sign-extends its low 12 bits,
    // so bit 11 is carried into the LUI half.
    always_comb begin
        fits_s    = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
        pair_ok_s = (bus.funct3 == 3'd0) && (bus.rs1 == 5'd0);
        hi_s      = bus.imm[31:12] + {19'd0, bus.imm[11]};
    end

    assign bus.in_ready  = (state_r == IDLE) && !rst;
    assign bus.busy      = (state_r != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_word  = out_word_r;
    assign bus.out_addr  = out_addr_r;
    assign bus.err       = err_r;

    // Encoder FSM with registered word, address and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_word_r  <= 32'h0000_0000;
            out_addr_r  <= BASE_ADDR;
            addr_r      <= BASE_ADDR;
            err_r       <= 1'b0;
            imm_lo_r    <= 12'h000;
            rd_lat_r    <= 5'd0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (fits_s) begin
                            out_word_r  <= enc_itype(bus.imm[11:0], bus.rs1, bus.funct3, bus.rd);
                            out_addr_r  <= addr_r;
                            out_valid_r <= 1'b1;
                            state_r     <= SINGLE;
                        end else if (pair_ok_s) begin
                            out_word_r  <= enc_utype(hi_s, bus.rd);
                            out_addr_r  <= addr_r;
                            out_valid_r <= 1'b1;
                            imm_lo_r    <= bus.imm[11:0];
                            rd_lat_r    <= bus.rd;
                            state_r     <= HI;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                SINGLE: begin
                    if (bus.out_ready) begin
                        addr_r      <= addr_r + STEP;
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                HI: begin
                    if (bus.out_ready) begin
                        addr_r     <= addr_r + STEP;
                        out_addr_r <= addr_r + STEP;
                        out_word_r <= enc_itype(imm_lo_r, rd_lat_r, 3'b000, rd_lat_r);
                        state_r    <= LO;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                LO: begin
                    if (bus.out_ready) begin
                        addr_r      <= addr_r + STEP;
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule
